// File: rtl/lbm_pkg.sv
// lbm_pkg: shared definitions for the lane mapper.
//   - lbm_mode_e : per-beat mapping mode encodings
//   - lane_map() : applies a mapping mode to up to LBM_MAX_W lanes, of which
//                  only the low 'width' lanes are meaningful
package lbm_pkg;

  localparam int LBM_MAX_W   = 64;
  localparam int LBM_IDX_W   = $clog2(LBM_MAX_W);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_REV  = 2'd1,
    MODE_MASK = 2'd2,
    MODE_ROTL = 2'd3
  } lbm_mode_e;

  typedef logic [LBM_MAX_W-1:0] lbm_lanes_t;

  // Lanes at or above 'width' are always returned as zero, so callers can
  // truncate the result to their own lane count.
  function automatic lbm_lanes_t lane_map(input lbm_lanes_t data,
                                          input logic [1:0] mode,
                                          input lbm_lanes_t mask,
                                          input int         width);
    lbm_lanes_t             res;
    logic [LBM_IDX_W-1:0]   w_dst;
    logic [LBM_IDX_W-1:0]   w_rev;
    logic [LBM_IDX_W-1:0]   w_rot;
    res = '0;
    for (int i = 0; i < LBM_MAX_W; i++) begin
      w_dst = LBM_IDX_W'(i);
      w_rev = LBM_IDX_W'(width - 1 - i);
      w_rot = LBM_IDX_W'((i + width - 1) % width);
      if (i < width) begin
        case (mode)
          MODE_PASS: res[w_dst] = data[w_dst];
          MODE_REV:  res[w_dst] = data[w_rev];
          MODE_MASK: res[w_dst] = data[w_dst] & mask[w_dst];
          MODE_ROTL: res[w_dst] = data[w_rot];
          default:   res[w_dst] = data[w_dst];
        endcase
      end else begin
        res[w_dst] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lbm_sync_fifo.sv
// lbm_sync_fifo: DEPTH-entry synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, rst        clock, synchronous active-high reset (discards contents)
//   i_push, i_wdata write request and data (ignored when full)
//   i_pop           read request (ignored when empty)
//   o_rdata         head entry, 0 when empty
//   o_full, o_empty occupancy flags
//   o_count         number of stored entries, 0..DEPTH
module lbm_sync_fifo
  import lbm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Storage array; contents are only visible through the empty-gated read.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lbm_lane_mapper.sv
// lbm_lane_mapper: maps each accepted beat (pass/reverse/mask/rotate-left)
// and buffers the result in an output FIFO; counts non-zero accepted beats.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_data, mode, lane_en sampled on accept
//   out_valid/out_ready  output handshake; out_data is the FIFO head (0 when empty)
//   active_cnt           saturating count of accepted beats with any lane set
//   any_seen             sticky: a non-zero beat has been accepted since reset
module lbm_lane_mapper
  import lbm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lane_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] active_cnt,
  output logic             any_seen
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] w_mapped;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CNT_W-1:0] r_active_cnt;
  logic             r_any_seen;

  // Occupancy and the full flag are cross-checked so a single bad flag can
  // never admit a push into a full FIFO. No pass-through when full.
  assign in_ready  = !rst && !w_full && (w_count < CW'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign w_mapped  = WIDTH'(lane_map(LBM_MAX_W'(in_data), mode,
                                     LBM_MAX_W'(lane_en), WIDTH));
  assign out_valid = !w_empty;

  lbm_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_wdata (w_mapped),
    .i_pop   (out_ready),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Activity tracking uses the raw beat, before any lane masking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active_cnt <= {CNT_W{1'b0}};
      r_any_seen   <= 1'b0;
    end else if (w_accept && (|in_data)) begin
      if (r_active_cnt != {CNT_W{1'b1}}) begin
        r_active_cnt <= r_active_cnt + CNT_W'(1);
      end else begin
        r_active_cnt <= r_active_cnt;
      end
      r_any_seen <= 1'b1;
    end else begin
      r_active_cnt <= r_active_cnt;
      r_any_seen   <= r_any_seen;
    end
  end

  assign active_cnt = r_active_cnt;
  assign any_seen   = r_any_seen;

endmodule
